// File: rtl/gps_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module : gps_cfg_sequencer
// Brief  : Buffers configuration frames and commits them to gps_gen_core on
//          C/A code-epoch boundaries, flushing the core on PRN/phase changes.
// Rev    : 1.0  initial release
// ============================================================================
module gps_cfg_sequencer #(
    parameter int FLUSH_CYCLES  = 4,
    parameter int EPOCH_TIMEOUT = 20000
) (
    input  logic        clk_in,
    input  logic        rst_in_n,
    input  logic        cfg_valid_in,
    input  logic        cfg_enable_in,
    input  logic [4:0]  cfg_n_sat_in,
    input  logic        cfg_noise_off_in,
    input  logic        cfg_signal_off_in,
    input  logic [15:0] cfg_ca_phase_in,
    input  logic [7:0]  cfg_doppler_in,
    input  logic [7:0]  cfg_snr_in,
    input  logic        epoch_in,
    output logic        ena_out,
    output logic [4:0]  n_sat_out,
    output logic        noise_off_out,
    output logic        signal_off_out,
    output logic [15:0] ca_phase_out,
    output logic [7:0]  doppler_out,
    output logic [7:0]  snr_out,
    output logic        commit_out,
    output logic        busy_out
);

    localparam int c_tcnt_w = (EPOCH_TIMEOUT > 1) ? $clog2(EPOCH_TIMEOUT) : 1;
    localparam int c_fcnt_w = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [c_tcnt_w-1:0] c_tcnt_last = c_tcnt_w'(EPOCH_TIMEOUT - 1);
    localparam logic [c_fcnt_w-1:0] c_fcnt_last = c_fcnt_w'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_RUN   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_pending;
    logic                  r_buf_enable;
    logic [4:0]            r_buf_n_sat;
    logic                  r_buf_noise_off;
    logic                  r_buf_signal_off;
    logic [15:0]           r_buf_ca_phase;
    logic [7:0]            r_buf_doppler;
    logic [7:0]            r_buf_snr;
    logic [c_tcnt_w-1:0]   r_tcnt;
    logic [c_fcnt_w-1:0]   r_fcnt;

    state_t                w_next_state;
    logic                  w_apply;
    logic                  w_hard;
    logic                  w_epoch_due;
    logic                  w_next_pending;

    always_comb begin
        w_hard       = (r_buf_n_sat != n_sat_out) || (r_buf_ca_phase != ca_phase_out);
        w_epoch_due  = epoch_in || (r_tcnt == c_tcnt_last);
        w_apply      = 1'b0;
        w_next_state = r_state;
        case (r_state)
            ST_OFF: begin
                if (r_pending) begin
                    w_apply      = 1'b1;
                    w_next_state = r_buf_enable ? ST_FLUSH : ST_OFF;
                end
            end
            ST_RUN: begin
                if (r_pending) begin
                    if (!r_buf_enable) begin
                        w_apply      = 1'b1;
                        w_next_state = ST_OFF;
                    end else begin
                        w_next_state = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // A disable request never waits for the epoch.
                if (!r_buf_enable) begin
                    w_apply      = 1'b1;
                    w_next_state = ST_OFF;
                end else if (w_epoch_due) begin
                    w_apply      = 1'b1;
                    w_next_state = w_hard ? ST_FLUSH : ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (r_fcnt == c_fcnt_last) begin
                    w_next_state = ST_RUN;
                end
            end
            default: w_next_state = ST_OFF;
        endcase
        // A frame arriving on the commit edge survives as the next pending frame.
        w_next_pending = cfg_valid_in | (r_pending & ~w_apply);
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            r_state          <= ST_OFF;
            r_pending        <= 1'b0;
            r_buf_enable     <= 1'b0;
            r_buf_n_sat      <= '0;
            r_buf_noise_off  <= 1'b0;
            r_buf_signal_off <= 1'b0;
            r_buf_ca_phase   <= '0;
            r_buf_doppler    <= '0;
            r_buf_snr        <= '0;
            r_tcnt           <= '0;
            r_fcnt           <= '0;
            ena_out          <= 1'b0;
            n_sat_out        <= '0;
            noise_off_out    <= 1'b0;
            signal_off_out   <= 1'b0;
            ca_phase_out     <= '0;
            doppler_out      <= '0;
            snr_out          <= '0;
            commit_out       <= 1'b0;
            busy_out         <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_pending <= w_next_pending;

            if (cfg_valid_in) begin
                r_buf_enable     <= cfg_enable_in;
                r_buf_n_sat      <= cfg_n_sat_in;
                r_buf_noise_off  <= cfg_noise_off_in;
                r_buf_signal_off <= cfg_signal_off_in;
                r_buf_ca_phase   <= cfg_ca_phase_in;
                r_buf_doppler    <= cfg_doppler_in;
                r_buf_snr        <= cfg_snr_in;
            end

            if (w_apply) begin
                n_sat_out      <= r_buf_n_sat;
                noise_off_out  <= r_buf_noise_off;
                signal_off_out <= r_buf_signal_off;
                ca_phase_out   <= r_buf_ca_phase;
                doppler_out    <= r_buf_doppler;
                snr_out        <= r_buf_snr;
            end
            commit_out <= w_apply;

            if (r_state == ST_WAIT) begin
                if (r_tcnt != {c_tcnt_w{1'b1}}) begin
                    r_tcnt <= r_tcnt + 1'b1;
                end
            end else begin
                r_tcnt <= '0;
            end

            if (r_state == ST_FLUSH) begin
                r_fcnt <= r_fcnt + 1'b1;
            end else begin
                r_fcnt <= '0;
            end

            ena_out  <= (w_next_state == ST_RUN) || (w_next_state == ST_WAIT);
            busy_out <= w_next_pending || (w_next_state == ST_FLUSH) || (w_next_state == ST_WAIT);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gps_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_gps_cfg_sequencer
// Brief  : Directed plus randomized bench for gps_cfg_sequencer against a
//          behavioural reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_gps_cfg_sequencer;

    localparam int FLUSH_CYCLES  = 4;
    localparam int EPOCH_TIMEOUT = 20000;

    typedef struct packed {
        logic        en;
        logic [4:0]  n_sat;
        logic        noise_off;
        logic        signal_off;
        logic [15:0] phase;
        logic [7:0]  doppler;
        logic [7:0]  snr;
    } frame_t;

    logic        clk_in = 1'b0;
    logic        rst_in_n = 1'b1;
    logic        cfg_valid_in = 1'b0;
    logic        cfg_enable_in = 1'b0;
    logic [4:0]  cfg_n_sat_in = '0;
    logic        cfg_noise_off_in = 1'b0;
    logic        cfg_signal_off_in = 1'b0;
    logic [15:0] cfg_ca_phase_in = '0;
    logic [7:0]  cfg_doppler_in = '0;
    logic [7:0]  cfg_snr_in = '0;
    logic        epoch_in = 1'b0;
    logic        ena_out;
    logic [4:0]  n_sat_out;
    logic        noise_off_out;
    logic        signal_off_out;
    logic [15:0] ca_phase_out;
    logic [7:0]  doppler_out;
    logic [7:0]  snr_out;
    logic        commit_out;
    logic        busy_out;

    gps_cfg_sequencer #(
        .FLUSH_CYCLES  (FLUSH_CYCLES),
        .EPOCH_TIMEOUT (EPOCH_TIMEOUT)
    ) u_dut (
        .clk_in            (clk_in),
        .rst_in_n          (rst_in_n),
        .cfg_valid_in      (cfg_valid_in),
        .cfg_enable_in     (cfg_enable_in),
        .cfg_n_sat_in      (cfg_n_sat_in),
        .cfg_noise_off_in  (cfg_noise_off_in),
        .cfg_signal_off_in (cfg_signal_off_in),
        .cfg_ca_phase_in   (cfg_ca_phase_in),
        .cfg_doppler_in    (cfg_doppler_in),
        .cfg_snr_in        (cfg_snr_in),
        .epoch_in          (epoch_in),
        .ena_out           (ena_out),
        .n_sat_out         (n_sat_out),
        .noise_off_out     (noise_off_out),
        .signal_off_out    (signal_off_out),
        .ca_phase_out      (ca_phase_out),
        .doppler_out       (doppler_out),
        .snr_out           (snr_out),
        .commit_out        (commit_out),
        .busy_out          (busy_out)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model: core on/off, remaining flush cycles, epoch wait age.
    frame_t pend_q[$];
    frame_t m_out;
    bit     m_running;
    bit     m_waiting;
    int     m_wait_age;
    int     m_flush_left;
    bit     m_commit;
    bit     m_busy;

    task automatic model_reset();
        pend_q.delete();
        m_out        = '0;
        m_running    = 1'b0;
        m_waiting    = 1'b0;
        m_wait_age   = 0;
        m_flush_left = 0;
        m_commit     = 1'b0;
        m_busy       = 1'b0;
    endtask

    task automatic model_step(input bit v, input frame_t fin, input bit ep);
        bit     apply;
        frame_t f;
        apply    = 1'b0;
        f        = (pend_q.size() != 0) ? pend_q[pend_q.size()-1] : '0;
        m_commit = 1'b0;
        if (m_flush_left > 0) begin
            m_flush_left--;
            if (m_flush_left == 0) m_running = 1'b1;
        end else if (!m_running) begin
            if (pend_q.size() != 0) begin
                apply = 1'b1;
                if (f.en) m_flush_left = FLUSH_CYCLES;
            end
        end else if (!m_waiting) begin
            if (pend_q.size() != 0) begin
                if (!f.en) begin
                    apply     = 1'b1;
                    m_running = 1'b0;
                end else begin
                    m_waiting  = 1'b1;
                    m_wait_age = 0;
                end
            end
        end else begin
            if (!f.en) begin
                apply     = 1'b1;
                m_running = 1'b0;
                m_waiting = 1'b0;
            end else if (ep || m_wait_age == EPOCH_TIMEOUT - 1) begin
                apply     = 1'b1;
                m_waiting = 1'b0;
                if (f.n_sat != m_out.n_sat || f.phase != m_out.phase) begin
                    m_running    = 1'b0;
                    m_flush_left = FLUSH_CYCLES;
                end
            end else begin
                m_wait_age++;
            end
        end
        if (apply) begin
            m_out    = f;
            m_commit = 1'b1;
            pend_q.delete();
        end
        if (v) begin
            pend_q.delete();
            pend_q.push_back(fin);
        end
        m_busy = (pend_q.size() != 0) || (m_flush_left > 0) || m_waiting;
    endtask

    // Compare process: every falling edge, full output vector vs model.
    initial begin
        logic [41:0] act;
        logic [41:0] exp;
        forever begin
            @(negedge clk_in);
            if (chk_en) begin
                act = {ena_out, commit_out, busy_out, n_sat_out, noise_off_out, signal_off_out,
                       ca_phase_out, doppler_out, snr_out};
                exp = {m_running, m_commit, m_busy, m_out.n_sat, m_out.noise_off, m_out.signal_off,
                       m_out.phase, m_out.doppler, m_out.snr};
                n_checks++;
                if (act !== exp) begin
                    n_fail++;
                    $display("FAIL model_compare t=%0t actual=%h required=%h", $time, act, exp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    function automatic frame_t mk(input bit en, input int ns, input int ph, input int dop, input int snr);
        frame_t f;
        f            = '0;
        f.en         = en;
        f.n_sat      = 5'(ns);
        f.phase      = 16'(ph);
        f.doppler    = 8'(dop);
        f.snr        = 8'(snr);
        return f;
    endfunction

    // Called at negedge+1; returns at the following negedge+1.
    task automatic step(input bit v, input frame_t fin, input bit ep);
        cfg_valid_in      = v;
        cfg_enable_in     = fin.en;
        cfg_n_sat_in      = fin.n_sat;
        cfg_noise_off_in  = fin.noise_off;
        cfg_signal_off_in = fin.signal_off;
        cfg_ca_phase_in   = fin.phase;
        cfg_doppler_in    = fin.doppler;
        cfg_snr_in        = fin.snr;
        epoch_in          = ep;
        if (rst_in_n) model_step(v, fin, ep);
        @(negedge clk_in);
        #1;
        cfg_valid_in = 1'b0;
        epoch_in     = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
    endtask

    task automatic apply_reset(input int cycles);
        rst_in_n = 1'b0;
        model_reset();
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_in);
            #1;
        end
        rst_in_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog t=%0t actual=timeout required=finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int     cnt;
        int     lows;
        bit     found;
        frame_t rf;

        @(negedge clk_in);
        #1;
        apply_reset(3);
        chk_en = 1'b1;
        chk("reset_ena", ena_out, 0);
        chk("reset_busy", busy_out, 0);
        chk("reset_nsat", n_sat_out, 0);

        // 1: enable from OFF goes straight to flush.
        step(1'b1, mk(1, 5, 100, 0, 0), 1'b0);
        chk("t1_no_commit_yet", commit_out, 0);
        chk("t1_busy_pending", busy_out, 1);
        idle(1);
        chk("t1_commit", commit_out, 1);
        chk("t1_nsat", n_sat_out, 5);
        chk("t1_phase", ca_phase_out, 100);
        lows = (ena_out == 1'b0) ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            if (ena_out == 1'b0) lows++;
        end
        chk("t1_flush_len", lows, 4);
        idle(1);
        chk("t1_ena_on", ena_out, 1);

        // 2: soft change waits for the epoch without disturbing ena_out.
        step(1'b1, mk(1, 5, 100, 8'h20, 0), 1'b0);
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            idle(1);
            if (commit_out) cnt++;
        end
        chk("t2_no_early_commit", cnt, 0);
        step(1'b0, '0, 1'b1);
        chk("t2_doppler", doppler_out, 8'h20);
        chk("t2_commit", commit_out, 1);
        chk("t2_ena", ena_out, 1);

        // 3: PRN change on epoch -> commit plus flush.
        step(1'b1, mk(1, 7, 100, 8'h20, 0), 1'b0);
        idle(5);
        step(1'b0, '0, 1'b1);
        chk("t3_nsat", n_sat_out, 7);
        cnt  = commit_out ? 1 : 0;
        lows = (ena_out == 1'b0) ? 1 : 0;
        for (int i = 0; i < 8; i++) begin
            idle(1);
            if (commit_out) cnt++;
            if (ena_out == 1'b0) lows++;
        end
        chk("t3_one_commit", cnt, 1);
        chk("t3_flush_len", lows, 4);

        // 4: no epoch -> forced commit after EPOCH_TIMEOUT cycles in WAIT.
        step(1'b1, mk(1, 7, 100, 8'h20, 8'h33), 1'b0);
        idle(1);
        found = 1'b0;
        for (int n = 1; n <= EPOCH_TIMEOUT + 10 && !found; n++) begin
            idle(1);
            if (commit_out) begin
                found = 1'b1;
                chk("t4_timeout_cycle", n, EPOCH_TIMEOUT);
            end
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL t4_timeout_seen actual=no_commit required=commit");
        end
        chk("t4_snr", snr_out, 8'h33);

        // 5: last frame wins while waiting.
        idle(2);
        step(1'b1, mk(1, 7, 100, 8'h11, 8'h33), 1'b0);
        idle(2);
        step(1'b1, mk(1, 7, 100, 8'h22, 8'h33), 1'b0);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            idle(1);
            if (commit_out) cnt++;
        end
        step(1'b0, '0, 1'b1);
        if (commit_out) cnt++;
        idle(3);
        chk("t5_one_commit", cnt, 1);
        chk("t5_doppler", doppler_out, 8'h22);

        // 6: disable is immediate; reset in WAIT drops the pending frame.
        step(1'b1, mk(0, 7, 100, 8'h22, 8'h33), 1'b0);
        idle(1);
        chk("t6_ena_off", ena_out, 0);
        chk("t6_commit", commit_out, 1);
        step(1'b1, mk(1, 7, 100, 8'h22, 8'h33), 1'b0);
        idle(6);
        step(1'b1, mk(1, 7, 100, 8'h22, 8'h44), 1'b0);
        idle(2);
        chk("t6_busy_wait", busy_out, 1);
        rst_in_n = 1'b0;
        model_reset();
        #1;
        chk("t6_rst_ena", ena_out, 0);
        chk("t6_rst_busy", busy_out, 0);
        chk("t6_rst_nsat", n_sat_out, 0);
        chk("t6_rst_doppler", doppler_out, 0);
        @(negedge clk_in);
        #1;
        rst_in_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            idle(1);
            if (commit_out) cnt++;
        end
        chk("t6_pending_lost", cnt, 0);
        chk("t6_idle_busy", busy_out, 0);

        // Randomized traffic, checked every cycle by the compare process.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(699) == 0) begin
                apply_reset(1);
            end else begin
                rf            = '0;
                rf.en         = ($urandom_range(7) != 0);
                rf.n_sat      = 5'($urandom_range(2));
                rf.phase      = 16'($urandom_range(1));
                rf.noise_off  = 1'($urandom_range(1));
                rf.signal_off = 1'($urandom_range(1));
                rf.doppler    = 8'($urandom);
                rf.snr        = 8'($urandom);
                step(($urandom_range(7) == 0), rf, ($urandom_range(15) == 0));
            end
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
